// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture block: segment width,
// legal hex patterns, pattern decoder and FSM state type.
// SEG7_CAPTURE_DP_EN widens the segment bus to carry the decimal point in bit 7.
package seg7_pkg;

`ifdef SEG7_CAPTURE_DP_EN
  localparam int unsigned SEG_W = 8;
`else
  localparam int unsigned SEG_W = 7;
`endif

  localparam int unsigned NUM_DIGITS_DEFAULT    = 6;
  localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

  // Active-low patterns, bit 6 = segment g ... bit 0 = segment a.
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  typedef enum logic {SYNC, COLLECT} seg7_state_e;

  // Returns {illegal, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      SEG_HEX_0: res = {1'b0, 4'h0};
      SEG_HEX_1: res = {1'b0, 4'h1};
      SEG_HEX_2: res = {1'b0, 4'h2};
      SEG_HEX_3: res = {1'b0, 4'h3};
      SEG_HEX_4: res = {1'b0, 4'h4};
      SEG_HEX_5: res = {1'b0, 4'h5};
      SEG_HEX_6: res = {1'b0, 4'h6};
      SEG_HEX_7: res = {1'b0, 4'h7};
      SEG_HEX_8: res = {1'b0, 4'h8};
      SEG_HEX_9: res = {1'b0, 4'h9};
      SEG_HEX_A: res = {1'b0, 4'hA};
      SEG_HEX_B: res = {1'b0, 4'hB};
      SEG_HEX_C: res = {1'b0, 4'hC};
      SEG_HEX_D: res = {1'b0, 4'hD};
      SEG_HEX_E: res = {1'b0, 4'hE};
      SEG_HEX_F: res = {1'b0, 4'hF};
      default:   res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_stable.sv
// Input register and stability qualifier. Emits a one-cycle capture pulse
// when a one-hot digit select and its pattern have been sampled unchanged
// for STABLE_CYCLES consecutive cycles, together with the digit index and
// the stable pattern.
module seg7_stable import seg7_pkg::*; #(
  parameter int unsigned NUM_DIGITS    = NUM_DIGITS_DEFAULT,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SEG_W-1:0]      seg_i,
  input  logic [NUM_DIGITS-1:0] sel_i,
  output logic                  capture_o,
  output logic [IdxW-1:0]       idx_o,
  output logic [SEG_W-1:0]      seg_o
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  logic [SEG_W-1:0]      seg_q, seg_prev_q;
  logic [NUM_DIGITS-1:0] sel_q, sel_prev_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  sel_onehot;
  logic                  same;

  assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
  assign same       = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);

  // Sample register S and its one-cycle-old copy, plus the run counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_q      <= '0;
      sel_q      <= '0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      seg_q      <= seg_i;
      sel_q      <= sel_i;
      seg_prev_q <= seg_q;
      sel_prev_q <= sel_q;
      cnt_q      <= cnt_d;
    end
  end

  // Run counter: cleared on blanking/multi-select, restarts on change, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (!sel_onehot) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Pulse only on arrival at the limit, not while sitting saturated.
    capture_o = sel_onehot && (cnt_d == CntMax) && !(same && (cnt_q == CntMax));
  end

  // One-hot to index.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) idx_o = IdxW'(i);
    end
  end

  assign seg_o = seg_q;

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment display bus receiver: qualifies each digit by stability,
// decodes it to a hex nibble, assembles a frame and presents it on a
// valid/ready output with a sticky overrun flag for dropped frames.
// Optional decimal-point capture is enabled by SEG7_CAPTURE_DP_EN.
module seg7_capture import seg7_pkg::*; #(
  parameter int unsigned NUM_DIGITS    = NUM_DIGITS_DEFAULT,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic [NUM_DIGITS-1:0]   out_err,
`ifdef SEG7_CAPTURE_DP_EN
  output logic [NUM_DIGITS-1:0]   out_dp,
`endif
  output logic                    overrun
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic              capture;
  logic [IdxW-1:0]   cap_idx;
  logic [SEG_W-1:0]  cap_seg;
  logic [4:0]        dec;

  seg7_stable #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stable (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .seg_i     (seg_in),
    .sel_i     (dig_sel),
    .capture_o (capture),
    .idx_o     (cap_idx),
    .seg_o     (cap_seg)
  );

  assign dec = seg7_decode(cap_seg[6:0]);

  seg7_state_e               state_q, state_d;
  logic [4*NUM_DIGITS-1:0]   nib_q, nib_d;
  logic [NUM_DIGITS-1:0]     err_q, err_d;
  logic [NUM_DIGITS-1:0]     mask_q, mask_d;
  logic                      valid_q, valid_d;
  logic [4*NUM_DIGITS-1:0]   value_q, value_d;
  logic [NUM_DIGITS-1:0]     oerr_q, oerr_d;
  logic                      overrun_q, overrun_d;
  logic                      take;
`ifdef SEG7_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0]     dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     odp_q, odp_d;
`endif

  // Frame store, FSM and output buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SYNC;
      nib_q     <= '0;
      err_q     <= '0;
      mask_q    <= '0;
      valid_q   <= 1'b0;
      value_q   <= '0;
      oerr_q    <= '0;
      overrun_q <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
      dp_q      <= '0;
      odp_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      nib_q     <= nib_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      value_q   <= value_d;
      oerr_q    <= oerr_d;
      overrun_q <= overrun_d;
`ifdef SEG7_CAPTURE_DP_EN
      dp_q      <= dp_d;
      odp_q     <= odp_d;
`endif
    end
  end

  // Store captures, detect frame completion and run the output handshake.
  always_comb begin
    state_d   = state_q;
    nib_d     = nib_q;
    err_d     = err_q;
    mask_d    = mask_q;
    valid_d   = valid_q;
    value_d   = value_q;
    oerr_d    = oerr_q;
    overrun_d = overrun_q;
`ifdef SEG7_CAPTURE_DP_EN
    dp_d      = dp_q;
    odp_d     = odp_q;
`endif
    take = 1'b0;

    if (capture) begin
      case (state_q)
        SYNC:    take = (cap_idx == '0);
        COLLECT: take = 1'b1;
        default: take = 1'b0;
      endcase
    end

    if (take) begin
      state_d = COLLECT;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (cap_idx == IdxW'(i)) begin
          nib_d[4*i +: 4] = dec[3:0];
          err_d[i]        = dec[4];
          mask_d[i]       = 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
          dp_d[i]         = ~cap_seg[7];
`endif
        end
      end
    end

    if (take && (&mask_d)) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        value_d = nib_d;
        oerr_d  = err_d;
`ifdef SEG7_CAPTURE_DP_EN
        odp_d   = dp_d;
`endif
      end else begin
        overrun_d = 1'b1;
      end
      mask_d = '0;
      err_d  = '0;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_value = value_q;
  assign out_err   = oerr_q;
  assign overrun   = overrun_q;
`ifdef SEG7_CAPTURE_DP_EN
  assign out_dp    = odp_q;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Testbench for seg7_capture: table-driven frames, hand-written corner
// sequences and random stimulus, all compared every cycle against a
// history-based reference model.
module tb_seg7_capture;
  import seg7_pkg::*;

  localparam int unsigned ND = 6;
  localparam int unsigned SC = 4;
  localparam int unsigned SW = SEG_W;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [SW-1:0]   seg_in;
  logic [ND-1:0]   dig_sel;
  logic            out_ready;
  logic            out_valid;
  logic [4*ND-1:0] out_value;
  logic [ND-1:0]   out_err;
  logic            overrun;
`ifdef SEG7_CAPTURE_DP_EN
  logic [ND-1:0]   out_dp;
`endif

  seg7_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_err   (out_err),
`ifdef SEG7_CAPTURE_DP_EN
    .out_dp    (out_dp),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Legal patterns indexed by hex value (bit 6 = g ... bit 0 = a, active-low).
  logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  logic [ND+SW-1:0] hist[$];
  bit               m_sync;
  bit [ND-1:0]      m_mask, m_err, m_dp;
  logic [3:0]       m_nib [ND];
  bit               m_valid, m_overrun;
  logic [4*ND-1:0]  m_value;
  logic [ND-1:0]    m_oerr, m_odp;

  // Frame observation.
  int               vcycles;
  logic [4*ND-1:0]  last_val;
  logic [ND-1:0]    last_err, last_dp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_sync = 1'b1; m_mask = '0; m_err = '0; m_dp = '0;
    for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
    m_valid = 1'b0; m_overrun = 1'b0; m_value = '0; m_oerr = '0; m_odp = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  // A digit is captured when the last SC samples are the same one-hot value
  // and the sample before them (or the reset value) differs.
  task automatic model_edge();
    int               n;
    bit               cap, take, free, deq, ill;
    logic [ND+SW-1:0] v;
    logic [ND-1:0]    sel;
    logic [3:0]       nib;
    int               idx;
    n = hist.size();
    cap = 1'b0;
    idx = 0;
    v = '0;
    if (n >= SC) begin
      v = hist[n-1];
      cap = 1'b1;
      for (int k = 1; k < SC; k++) if (hist[n-1-k] != v) cap = 1'b0;
      if (n > SC && hist[n-1-SC] == v) cap = 1'b0;
      sel = v[ND+SW-1:SW];
      if ($countones(sel) != 1) cap = 1'b0;
      for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
    end
    hist.push_back({dig_sel, seg_in});
    if (hist.size() > SC + 1) void'(hist.pop_front());

    nib = 4'h0;
    ill = 1'b1;
    for (int p = 0; p < 16; p++) begin
      if (pat_tab[p] == v[6:0]) begin
        nib = p[3:0];
        ill = 1'b0;
      end
    end

    free = !m_valid || out_ready;
    deq  = m_valid && out_ready;
    take = cap && (!m_sync || idx == 0);
    if (take) begin
      m_sync = 1'b0;
      m_nib[idx] = nib;
      m_err[idx] = ill;
      m_mask[idx] = 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
      m_dp[idx] = ~v[7];
`endif
    end
    if (take && m_mask == '1) begin
      if (free) begin
        m_valid = 1'b1;
        for (int i = 0; i < ND; i++) m_value[4*i +: 4] = m_nib[i];
        m_oerr = m_err;
        m_odp  = m_dp;
      end else begin
        m_overrun = 1'b1;
      end
      m_mask = '0;
      m_err  = '0;
    end else if (deq) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("valid", 64'(out_valid), 64'(m_valid));
    check("value", 64'(out_value), 64'(m_value));
    check("err", 64'(out_err), 64'(m_oerr));
    check("overrun", 64'(overrun), 64'(m_overrun));
`ifdef SEG7_CAPTURE_DP_EN
    check("dp", 64'(out_dp), 64'(m_odp));
`endif
  endtask

  task automatic drive(input logic [SW-1:0] s, input logic [ND-1:0] d, input logic rdy,
                       input int n);
    for (int i = 0; i < n; i++) begin
      seg_in = s;
      dig_sel = d;
      out_ready = rdy;
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
      if (out_valid) begin
        vcycles++;
        last_val = out_value;
        last_err = out_err;
`ifdef SEG7_CAPTURE_DP_EN
        last_dp = out_dp;
`endif
      end
    end
  endtask

  function automatic logic [SW-1:0] mk(input logic [6:0] p, input bit dp_lit);
    logic [SW-1:0] r;
    r = '1;
    r[6:0] = p;
`ifdef SEG7_CAPTURE_DP_EN
    r[SW-1] = ~dp_lit;
`else
    if (dp_lit) r = r;
`endif
    return r;
  endfunction

  function automatic logic [ND-1:0] onehot(input int d);
    logic [ND-1:0] s;
    s = '0;
    s[d] = 1'b1;
    return s;
  endfunction

  // Show digits 0..ND-1 in order; bad[d] shows the blank (illegal) pattern.
  task automatic scan(input logic [4*ND-1:0] show, input logic [ND-1:0] bad,
                      input logic [ND-1:0] dps, input logic rdy, input int hold);
    logic [6:0] p;
    for (int d = 0; d < ND; d++) begin
      p = bad[d] ? 7'h7F : pat_tab[show[4*d +: 4]];
      drive(mk(p, dps[d]), onehot(d), rdy, hold);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_value", 64'(out_value), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [4*ND-1:0] show;
    logic [ND-1:0]   bad;
    logic [4*ND-1:0] exp_val;
    logic [ND-1:0]   exp_err;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{show: 24'h654321, bad: 6'b000000, exp_val: 24'h654321, exp_err: 6'b000000};
    vecs[1] = '{show: 24'hFEDCBA, bad: 6'b000000, exp_val: 24'hFEDCBA, exp_err: 6'b000000};
    vecs[2] = '{show: 24'h987654, bad: 6'b001000, exp_val: 24'h980654, exp_err: 6'b001000};
    vecs[3] = '{show: 24'h0A0B0C, bad: 6'b100001, exp_val: 24'h0A0B00, exp_err: 6'b100001};

    seg_in = '1;
    dig_sel = '0;
    out_ready = 1'b1;
    vcycles = 0;
    last_val = '0;
    last_err = '0;
    last_dp = '0;
    do_reset();

    // Table-driven frames, one valid cycle each with out_ready held high.
    for (int t = 0; t < 4; t++) begin
      vcycles = 0;
      scan(vecs[t].show, vecs[t].bad, '0, 1'b1, 6);
      drive(mk(7'h7F, 1'b0), '0, 1'b1, 2);
      check("tbl_vcycles", 64'(vcycles), 64'd1);
      check("tbl_value", 64'(last_val), 64'(vecs[t].exp_val));
      check("tbl_err", 64'(last_err), 64'(vecs[t].exp_err));
    end

    // Glitching digit 2 only captures once it holds A long enough.
    vcycles = 0;
    drive(mk(pat_tab[1], 1'b0), onehot(0), 1'b1, 6);
    drive(mk(pat_tab[2], 1'b0), onehot(1), 1'b1, 6);
    for (int g = 0; g < 4; g++) begin
      drive(mk(pat_tab[3], 1'b0), onehot(2), 1'b1, 2);
      drive(mk(pat_tab[7], 1'b0), onehot(2), 1'b1, 2);
    end
    drive(mk(pat_tab[10], 1'b0), onehot(2), 1'b1, 4);
    drive(mk(pat_tab[4], 1'b0), onehot(3), 1'b1, 6);
    drive(mk(pat_tab[5], 1'b0), onehot(4), 1'b1, 6);
    drive(mk(pat_tab[6], 1'b0), onehot(5), 1'b1, 6);
    check("glitch_vcycles", 64'(vcycles), 64'd1);
    check("glitch_value", 64'(last_val), 64'h654A21);

    // Backpressure: first frame held, second dropped, overrun sticky.
    scan(24'h111111, '0, '0, 1'b0, 6);
    check("bp_valid1", 64'(out_valid), 64'd1);
    check("bp_value1", 64'(out_value), 64'h111111);
    check("bp_overrun1", 64'(overrun), 64'd0);
    scan(24'h222222, '0, '0, 1'b0, 6);
    check("bp_valid2", 64'(out_valid), 64'd1);
    check("bp_value2", 64'(out_value), 64'h111111);
    check("bp_overrun2", 64'(overrun), 64'd1);
    drive(mk(7'h7F, 1'b0), '0, 1'b1, 1);
    check("bp_drop_valid", 64'(out_valid), 64'd0);
    check("bp_sticky", 64'(overrun), 64'd1);

    // Reset released mid-scan: digits 4 and 5 must not start a frame.
    seg_in = mk(pat_tab[8], 1'b0);
    dig_sel = onehot(4);
    do_reset();
    vcycles = 0;
    drive(mk(pat_tab[8], 1'b0), onehot(4), 1'b1, 6);
    drive(mk(pat_tab[9], 1'b0), onehot(5), 1'b1, 6);
    check("mid_novalid", 64'(vcycles), 64'd0);
    check("mid_overrun", 64'(overrun), 64'd0);
    scan(24'h123456, '0, '0, 1'b1, 6);
    check("mid_vcycles", 64'(vcycles), 64'd1);
    check("mid_value", 64'(last_val), 64'h123456);

`ifdef SEG7_CAPTURE_DP_EN
    // Decimal point on digit 1 is reported without affecting legality.
    vcycles = 0;
    scan(24'h000010, '0, 6'b000010, 1'b1, 6);
    check("dp_vcycles", 64'(vcycles), 64'd1);
    check("dp_value", 64'(last_val), 64'h000010);
    check("dp_bits", 64'(last_dp), 64'b000010);
    check("dp_err", 64'(last_err), 64'd0);
`endif

    // Random scanning, patterns, hold lengths and backpressure.
    do_reset();
    begin
      int seq;
      int d;
      logic [ND-1:0] sel;
      logic [6:0] p;
      seq = 0;
      for (int r = 0; r < 400; r++) begin
        if ($urandom_range(0, 9) < 7) begin
          d = seq % ND;
          seq++;
        end else begin
          d = $urandom_range(0, ND - 1);
        end
        sel = onehot(d);
        case ($urandom_range(0, 19))
          0: sel = '0;
          1: sel = sel | onehot($urandom_range(0, ND - 1));
          default: ;
        endcase
        p = ($urandom_range(0, 9) < 8) ? pat_tab[$urandom_range(0, 15)]
                                       : 7'($urandom_range(0, 127));
        drive(mk(p, 1'($urandom_range(0, 1))), sel, 1'($urandom_range(0, 1)),
              $urandom_range(1, 8));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
